// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store data memory with effective-address generation,
// RV32I byte/half/word accesses, configurable read latency and error reporting.
module data_mem_unit #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  use_part,
  input  logic [2:0]  op_mode2,
  input  logic [31:0] op1,
  input  logic [31:0] imm_data,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] res
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam int         EA_W     = ADDR_WIDTH + 2;
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [EA_W-1:0]   ea_q, ea_d;
  logic [31:0]       op2_q, op2_d;
  logic [31:0]       res_q, res_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       ea;
  logic              is_load, is_store, f3_ok, misaligned, out_of_range;
  logic              req_err, accept;
  logic [31:0]       rd_word, load_val;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  // Decode and validate the incoming request in the start cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    f3_ok        = 1'b0;
    ea           = op1 + imm_data;
    is_load      = (use_part == 2'b01);
    is_store     = (use_part == 2'b10);
    if (is_load)       f3_ok = op_mode2 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store) f3_ok = op_mode2 inside {3'b000, 3'b001, 3'b010};
    misaligned   = ((op_mode2[1:0] == 2'b01) && ea[0]) ||
                   ((op_mode2[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    out_of_range = (ea >> EA_W) != 32'd0;
    req_err      = (is_load || is_store) && (!f3_ok || misaligned || out_of_range);
    accept       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Select and extend the addressed lane of the captured load address.
  always_comb begin
    rd_word = mem[ea_q[EA_W-1:2]];
    case (ea_q[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = ea_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Byte enables and lane-replicated write data for the captured store.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << ea_q[1:0];
        wr_data = {4{op2_q[7:0]}};
      end
      2'b01: begin
        wr_be   = ea_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{op2_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = op2_q;
      end
    endcase
  end

  // Byte-enabled storage write, performed on the edge that leaves WR.
  // NOTE: the storage array has no reset; contents survive rst and map onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_WR) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[ea_q[EA_W-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // State and request registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      funct3_q <= 3'd0;
      ea_q     <= '0;
      op2_q    <= 32'd0;
      res_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      ea_q     <= ea_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Next-state: dispatch from IDLE/DONE, count read latency, finish stores.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    ea_d     = ea_q;
    op2_d    = op2_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          funct3_d = op_mode2;
          ea_d     = ea[EA_W-1:0];
          op2_d    = op2;
          cnt_d    = 2'd0;
          if (req_err) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            res_d   = 32'd0;
          end else if (is_load) begin
            state_d = S_RD_WAIT;
          end else if (is_store) begin
            state_d = S_WR;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_DONE;
          cnt_d   = 2'd0;
          res_d   = load_val;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = S_DONE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Outputs decoded from the state and result registers.
  always_comb begin
    busy = (state_q == S_RD_WAIT) || (state_q == S_WR);
    done = (state_q == S_DONE);
    err  = err_q;
    res  = res_q;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised load/store data memory for the RV052B core, the successor to the fixed single-cycle data RAM. It accepts one load or store per start pulse, computes the effective address from a base and an immediate, and performs RV32I byte/half/word accesses with sign or zero extension. It also adds a configurable memory depth, a configurable read latency, a busy flag, and misaligned/out-of-range error reporting. It sits between the execute stage and the write-back mux.

## Interface

- ADDR_WIDTH, 10: word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 1: load latency of the storage array in cycles, legal 1..4.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled only when busy=0
- use_part  in  2  01 load, 10 store, 00/11 no-op
- op_mode2  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- op1  in  32  base address
- imm_data  in  32  sign-extended offset
- op2  in  32  store data (low byte/half used for SB/SH)
- busy  out  1  request in flight
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, out-of-range or illegal funct3
- res  out  32  load result, valid with done, held until next done

## Operation

- The effective address is ea = op1 + imm_data, computed mod 2^32. The word index is ea[ADDR_WIDTH+1:2], and the byte lane is ea[1:0].
- Error conditions, checked in the start cycle:
  - H access with ea[0]=1
  - W access with ea[1:0]≠0
  - ea[31:ADDR_WIDTH+2]≠0
  - funct3 not listed for the given use_part
- On error: no memory write, res=0, err=1 with done.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW returns the word unchanged.
- Store: a read-modify-free byte-enabled write. Only the addressed lanes change: SB sets 1 lane, SH sets 2 lanes (ea[1] selects the half), SW sets all 4.
- A no-op use_part with start completes as a 1-cycle done with err=0 and res unchanged.
- start while busy=1 is ignored; no queueing.
- All request fields (use_part, op_mode2, ea, op2) are captured into registers at the start edge. Later input changes do not affect an in-flight request.
- FSM states:
  - IDLE → (start) CHECK-and-dispatch on the same edge.
  - Loads go to RD_WAIT, which counts READ_LATENCY cycles, then DONE.
  - Stores go to WR, then DONE.
  - Errors and no-ops go directly to DONE.
  - DONE → IDLE.
- Memory contents are not affected by reset.

## Timing

- Take start sampled high at edge T0.
- Latency to the done pulse (high for one cycle after the edge):
  - error / no-op: T0+1
  - store: T0+2 (the write takes effect at edge T0+1)
  - load: T0+1+READ_LATENCY
- busy is high from after T0 until the edge that raises done. busy is low during the done cycle, so a new start may be sampled in the done cycle (back-to-back throughput of latency cycles per op).
- A load immediately following a store to the same word returns the stored data.
- res and err update only on the edge that raises done.
- Reset values: busy=0, done=0, err=0, res=0, FSM=IDLE, latency counter=0.
- Reset asserted mid-operation aborts the request with no done pulse. A store whose write edge has already occurred stays written; one whose write edge has not occurred is not written.

## Test plan

- SW then LW, READ_LATENCY=1: op1=0, imm=8, op2=0xDEADBEEF store → done at T0+2, err=0. LW from the same address → done at T0+2, res=0xDEADBEEF.
- SB/LB/LBU lanes: memory word 0 = 0x00000000. SB op2=0x000000F0 to ea=3 → word 0 = 0xF0000000. LB ea=3 → res=0xFFFFFFF0. LBU ea=3 → res=0x000000F0.
- SH/LH with negative offset: op1=0x10, imm=0xFFFFFFFE, SH op2=0x00008001 → ea=0xE, word 3 bits[31:16]=0x8001. LH → 0xFFFF8001. LHU → 0x00008001.
- Errors: LW ea=2 → err=1, res=0, done at T0+1, memory unchanged. SW ea=4·2^ADDR_WIDTH → err=1, no write. use_part=01, funct3=011 → err=1.
- Latency/busy with READ_LATENCY=3: LW → done exactly at T0+4. A second start asserted while busy is ignored. A start in the done cycle is accepted.
- Reset mid-load with READ_LATENCY=4: assert rst at T0+2 → busy, done, err and res go to 0 immediately, no done pulse follows, and previously stored data is intact.
